// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from an upstream FIFO valid/ready port and
// serialises them as start + 8 data (LSB first) + optional parity + stop bit(s).
module uart_fifo_tx #(
    parameter int    CLKS_PER_BIT = 434,
    parameter string PARITY       = "NONE",
    parameter int    STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_rd_valid,
    output logic       fifo_rd_req,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int           BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]   STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit           PAR_EN    = (PARITY != "NONE");
    localparam logic         PAR_ODD   = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    state_e      state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    assign fifo_rd_req = (state_q == S_IDLE);
    assign tx_busy     = (state_q != S_IDLE);
    assign uart_tx     = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fifo_rd_valid) begin
                    shift_d = fifo_rd_data;
                    par_d   = (^fifo_rd_data) ^ PAR_ODD;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // bit counter doubles as the stop-bit counter
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is registered from the next-state view so it changes on the same edge
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: four instances (NONE/EVEN/ODD/2-stop) with a
// handshake-driven scoreboard and a negedge line monitor.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
    localparam int NL  = 4;

    typedef struct {
        logic [11:0] bits;
        int          n;
    } frame_t;

    logic                 clk;
    logic                 rst_n;
    logic [NL-1:0][7:0]   rd_data;
    logic [NL-1:0]        rd_valid;
    logic [NL-1:0]        rd_req;
    logic [NL-1:0]        tx;
    logic [NL-1:0]        busy;

    // expected frame for the byte currently presented on each lane (line order, bit 0 first)
    logic [11:0] exp_bits [NL];
    int          exp_n    [NL];
    int          exp_gap  [NL];
    int          stim_to;

    int     n_vec, n_bad, cyc, seen_to;
    frame_t sb [NL][$];
    frame_t cur [NL];
    int     pos [NL];
    bit     in_frame [NL];
    int     last_hs [NL];

    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY("NONE"), .STOP_BITS(1)) u_none (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(rd_data[0]), .fifo_rd_valid(rd_valid[0]),
        .fifo_rd_req(rd_req[0]), .uart_tx(tx[0]), .tx_busy(busy[0]));
    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY("EVEN"), .STOP_BITS(1)) u_even (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(rd_data[1]), .fifo_rd_valid(rd_valid[1]),
        .fifo_rd_req(rd_req[1]), .uart_tx(tx[1]), .tx_busy(busy[1]));
    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY("ODD"), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(rd_data[2]), .fifo_rd_valid(rd_valid[2]),
        .fifo_rd_req(rd_req[2]), .uart_tx(tx[2]), .tx_busy(busy[2]));
    uart_fifo_tx #(.CLKS_PER_BIT(CPB), .PARITY("NONE"), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(rd_data[3]), .fifo_rd_valid(rd_valid[3]),
        .fifo_rd_req(rd_req[3]), .uart_tx(tx[3]), .tx_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int l, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s lane %0d cyc %0d: got %0d, want %0d", nm, l, cyc, act, exp);
        end
    endtask

    // Monitor: sole owner of the counters and the scoreboard queues
    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; seen_to = 0;
        for (int l = 0; l < NL; l++) begin
            in_frame[l] = 1'b0; pos[l] = 0; last_hs[l] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (stim_to != seen_to) begin
                n_vec++; n_bad++;
                $display("FAIL pop_timeout: %0d waits expired, want 0", stim_to - seen_to);
                seen_to = stim_to;
            end
            for (int l = 0; l < NL; l++) begin
                if (!rst_n) begin
                    chk("rst_tx", l, int'(tx[l]), 1);
                    chk("rst_busy", l, int'(busy[l]), 0);
                    chk("rst_req", l, int'(rd_req[l]), 1);
                    in_frame[l] = 1'b0;
                    sb[l].delete();
                end else begin
                    if (!in_frame[l] && sb[l].size() != 0) begin
                        cur[l] = sb[l].pop_front();
                        pos[l] = 0;
                        in_frame[l] = 1'b1;
                    end
                    if (in_frame[l]) begin
                        chk("frame_tx", l, int'(tx[l]), int'(cur[l].bits[pos[l] / CPB]));
                        chk("frame_busy", l, int'(busy[l]), 1);
                        chk("frame_req", l, int'(rd_req[l]), 0);
                        pos[l]++;
                        if (pos[l] == cur[l].n * CPB) in_frame[l] = 1'b0;
                    end else begin
                        chk("idle_tx", l, int'(tx[l]), 1);
                        chk("idle_busy", l, int'(busy[l]), 0);
                        chk("idle_req", l, int'(rd_req[l]), 1);
                    end
                    if (rd_req[l] && rd_valid[l]) begin
                        frame_t f;
                        f.bits = exp_bits[l];
                        f.n    = exp_n[l];
                        sb[l].push_back(f);
                        if (exp_gap[l] != 0) chk("pop_gap", l, cyc - last_hs[l], exp_gap[l]);
                        last_hs[l] = cyc;
                    end
                end
            end
        end
    end

    task automatic present(input int l, input logic [7:0] d, input logic [11:0] f,
                           input int n, input int gap);
        rd_data[l]  = d;
        rd_valid[l] = 1'b1;
        exp_bits[l] = f;
        exp_n[l]    = n;
        exp_gap[l]  = gap;
    endtask

    // Returns at posedge+1 just after the handshake edge
    task automatic wait_pop(input int l);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_req[l] && rd_valid[l]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) stim_to++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_to  = 0;
        rst_n    = 1'b0;
        rd_valid = '0;
        rd_data  = '0;
        for (int l = 0; l < NL; l++) begin
            exp_bits[l] = '0; exp_n[l] = 0; exp_gap[l] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // single 0x55, 8N1: line 0,1,0,1,0,1,0,1,0,1
        present(0, 8'h55, 12'b0010_1010_1010, 10, 0);
        wait_pop(0);
        rd_valid[0] = 1'b0;
        repeat (45) @(posedge clk);
        #1;

        // back-to-back 0xA5 then 0x3C, pops 41 clk apart
        present(0, 8'hA5, 12'b0011_0100_1010, 10, 0);
        wait_pop(0);
        present(0, 8'h3C, 12'b0010_0111_1000, 10, 41);
        wait_pop(0);
        rd_valid[0] = 1'b0;
        repeat (45) @(posedge clk);
        #1;

        // 0x07 with even parity (par=1) and odd parity (par=0)
        present(1, 8'h07, 12'b0110_0000_1110, 11, 0);
        wait_pop(1);
        rd_valid[1] = 1'b0;
        present(2, 8'h07, 12'b0100_0000_1110, 11, 0);
        wait_pop(2);
        rd_valid[2] = 1'b0;
        repeat (50) @(posedge clk);
        #1;

        // two stop bits, two 0x00 bytes back-to-back, pops 45 apart
        present(3, 8'h00, 12'b0110_0000_0000, 11, 0);
        wait_pop(3);
        present(3, 8'h00, 12'b0110_0000_0000, 11, 45);
        wait_pop(3);
        rd_valid[3] = 1'b0;
        repeat (50) @(posedge clk);
        #1;

        // async reset mid-DATA; FIFO empty afterwards
        present(0, 8'h55, 12'b0010_1010_1010, 10, 0);
        wait_pop(0);
        rd_valid[0] = 1'b0;
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // long idle, then single-cycle valid with 0xFF
        repeat (100) @(posedge clk);
        #1;
        present(0, 8'hFF, 12'b0011_1111_1110, 10, 0);
        wait_pop(0);
        rd_valid[0] = 1'b0;
        rd_data[0]  = 8'h00;
        repeat (45) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
